// File: rtl/ofdm_tx_symbol_packer_pkg.sv
// Shared constants for the OFDM Tx symbol packer: default frame geometry,
// FSM state codes and small sizing helpers.
package ofdm_tx_pkg;

  localparam int FRAME_BITS_DEF   = 224;
  localparam int BITS_PER_SYM_DEF = 4;
  localparam int SYMS_PER_FRAME   = FRAME_BITS_DEF / BITS_PER_SYM_DEF;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_FILL = 3'd1;
  localparam logic [2:0] ST_LAST = 3'd2;
  localparam logic [2:0] ST_OUT  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  function automatic int syms_per_frame(input int frame_bits, input int bits_per_sym);
    return frame_bits / bits_per_sym;
  endfunction

  // Counters indexing n items need at least one bit even when n is 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ofdm_tx_symbol_packer_if.sv
// AXI-Stream style symbol bus from the packer to the QAM mapper / IFFT stage.
interface ofdm_tx_symbol_packer_if
  import ofdm_tx_pkg::*;
#(
  parameter int DATA_W = BITS_PER_SYM_DEF
);

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/ofdm_tx_bit_gather.sv
// Collects the serial buffer bits of one symbol and maps them to a constellation
// index; Gray coding is selected by defining OFDM_TX_GRAY_MAP_EN.
module ofdm_tx_bit_gather
  import ofdm_tx_pkg::*;
#(
  parameter int BITS_PER_SYM = BITS_PER_SYM_DEF,
  parameter int IDX_W        = cnt_width(BITS_PER_SYM)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cap_en,
  input  logic [IDX_W-1:0]        cap_idx,
  input  logic                    bit_in,
  output logic [BITS_PER_SYM-1:0] sym
);

  logic [BITS_PER_SYM-1:0] bits_b;

  // The top bit is never stored: it arrives in the same cycle the symbol is loaded.
  if (BITS_PER_SYM > 1) begin : g_multi
    logic [BITS_PER_SYM-2:0] sh;

    always_ff @(posedge clk) begin
      if (reset) begin
        sh <= '0;
      end else if (cap_en) begin
        sh[cap_idx] <= bit_in;
      end
    end

    assign bits_b = {bit_in, sh};
  end else begin : g_single
    assign bits_b = bit_in;
  end

`ifdef OFDM_TX_GRAY_MAP_EN
  assign sym = bits_b ^ (bits_b >> 1);
`else
  assign sym = bits_b;
`endif

endmodule

// File: rtl/ofdm_tx_symbol_packer.sv
// Walks the input bit buffer across one frame, packs LSB-first symbols onto an
// AXI-Stream master and pulses frame_done. Optional macro: OFDM_TX_GRAY_MAP_EN.
module ofdm_tx_symbol_packer
  import ofdm_tx_pkg::*;
#(
  parameter int FRAME_BITS   = FRAME_BITS_DEF,
  parameter int BITS_PER_SYM = BITS_PER_SYM_DEF,
  parameter int PTR_W        = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              buff_full,
  output logic [PTR_W-1:0]                  rd_pointer,
  input  logic                              bit_in,
  ofdm_tx_symbol_packer_if.master           m_axis,
  output logic                              frame_done,
  output logic                              busy
);

  localparam int SYMS  = syms_per_frame(FRAME_BITS, BITS_PER_SYM);
  localparam int BIT_W = cnt_width(BITS_PER_SYM);
  localparam int SYM_W = cnt_width(SYMS);

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BITS_PER_SYM - 1);
  localparam logic [SYM_W-1:0] LAST_SYM = SYM_W'(SYMS - 1);

  logic [2:0]              state;
  logic                    armed;
  logic [BIT_W-1:0]        bit_cnt;
  logic [SYM_W-1:0]        sym_cnt;
  logic                    cap_en;
  logic [BIT_W-1:0]        cap_idx;
  logic [BITS_PER_SYM-1:0] sym;

  // Fill cycle k sees the bit addressed in cycle k-1, so capture starts at k=1.
  assign cap_en  = (state == ST_FILL) && (bit_cnt != '0);
  assign cap_idx = bit_cnt - 1'b1;
  assign busy    = (state != ST_IDLE);

  ofdm_tx_bit_gather #(
    .BITS_PER_SYM (BITS_PER_SYM),
    .IDX_W        (BIT_W)
  ) u_gather (
    .clk     (clk),
    .reset   (reset),
    .cap_en  (cap_en),
    .cap_idx (cap_idx),
    .bit_in  (bit_in),
    .sym     (sym)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      armed         <= 1'b1;
      bit_cnt       <= '0;
      sym_cnt       <= '0;
      rd_pointer    <= '0;
      m_axis.tdata  <= '0;
      m_axis.tvalid <= 1'b0;
      m_axis.tlast  <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // armed stops a still-high buff_full from replaying the frame just sent.
          if (!buff_full) begin
            armed <= 1'b1;
          end else if (armed) begin
            state      <= ST_FILL;
            bit_cnt    <= '0;
            sym_cnt    <= '0;
            rd_pointer <= '0;
          end
        end

        ST_FILL: begin
          if (bit_cnt == LAST_BIT) begin
            state <= ST_LAST;
          end else begin
            bit_cnt    <= bit_cnt + 1'b1;
            rd_pointer <= rd_pointer + 1'b1;
          end
        end

        ST_LAST: begin
          m_axis.tdata  <= sym;
          m_axis.tvalid <= 1'b1;
          m_axis.tlast  <= (sym_cnt == LAST_SYM);
          state         <= ST_OUT;
        end

        ST_OUT: begin
          if (m_axis.tready) begin
            m_axis.tvalid <= 1'b0;
            m_axis.tlast  <= 1'b0;
            if (sym_cnt == LAST_SYM) begin
              state      <= ST_DONE;
              frame_done <= 1'b1;
              rd_pointer <= '0;
            end else begin
              state      <= ST_FILL;
              sym_cnt    <= sym_cnt + 1'b1;
              bit_cnt    <= '0;
              rd_pointer <= rd_pointer + 1'b1;
            end
          end
        end

        ST_DONE: begin
          armed      <= 1'b0;
          rd_pointer <= '0;
          sym_cnt    <= '0;
          bit_cnt    <= '0;
          state      <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ofdm_tx_symbol_packer.sv
// Self-checking bench for ofdm_tx_symbol_packer: registered-read buffer model,
// per-frame symbol reference computed directly from the frame bits.
module tb_ofdm_tx_symbol_packer;

  localparam int FRAME_BITS = 224;
  localparam int BPS        = 4;
  localparam int SYMS       = FRAME_BITS / BPS;

  logic       clk = 1'b0;
  logic       reset;
  logic       buff_full;
  logic [7:0] rd_pointer;
  logic       bit_in;
  logic       frame_done;
  logic       busy;

  ofdm_tx_symbol_packer_if #(.DATA_W(BPS)) axis_if ();

  ofdm_tx_symbol_packer #(
    .FRAME_BITS   (FRAME_BITS),
    .BITS_PER_SYM (BPS),
    .PTR_W        (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .buff_full  (buff_full),
    .rd_pointer (rd_pointer),
    .bit_in     (bit_in),
    .m_axis     (axis_if),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  logic [FRAME_BITS-1:0] frame_mem;

  // Buffer returns data[rd_pointer] one clock after the pointer is presented.
  always @(posedge clk) begin
    bit_in <= (rd_pointer < 8'(FRAME_BITS)) ? frame_mem[rd_pointer] : 1'b0;
  end

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [3:0] beats[$];
  int tlast_cnt, tlast_idx, done_cycle, done_cnt, first_valid;
  int ptr_steps, ptr_bad, stable_bad, stall_bad, stall_cycles, busy_at1;
  bit timed_out;
  int rst_tvalid, rst_tlast, rst_busy, rst_ptr, rst_after_bad;

  function automatic logic [3:0] exp_sym(input int i);
    logic [3:0] b;
    b = frame_mem[i*BPS +: BPS];
`ifdef OFDM_TX_GRAY_MAP_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_frame();
    for (int i = 0; i < FRAME_BITS / 32; i++) frame_mem[i*32 +: 32] = $urandom;
  endtask

  // mode 0: tready high, 1: random tready, 2: 10-cycle stall on beat 3, 3: reset on beat 20
  task automatic run_frame(input int mode);
    int cyc, prev_ptr, cur;
    bit prev_hold, rdy;
    logic [3:0] prev_data;
    logic prev_last;
    beats.delete();
    tlast_cnt = 0; tlast_idx = -1; done_cycle = -1; done_cnt = 0; first_valid = -1;
    ptr_steps = 0; ptr_bad = 0; stable_bad = 0; stall_bad = 0; stall_cycles = 0;
    busy_at1 = 0; timed_out = 1'b0;
    prev_ptr = int'(rd_pointer); prev_hold = 1'b0; prev_data = '0; prev_last = 1'b0;
    rdy = 1'b1;
    axis_if.tready = (mode == 2) ? 1'b0 : 1'b1;
    buff_full = 1'b1;
    cyc = 0;
    while (cyc < 1500) begin
      tick();
      cyc++;
      if (cyc == 1) busy_at1 = int'(busy);
      if (mode == 1 && cyc == 10) buff_full = 1'b0;
      if (prev_hold && (axis_if.tvalid !== 1'b1 || axis_if.tdata !== prev_data ||
                        axis_if.tlast !== prev_last)) stable_bad++;
      cur = int'(rd_pointer);
      if (cur != prev_ptr) begin
        if (cur == prev_ptr + 1) ptr_steps++;
        else if (!(cur == 0 && frame_done === 1'b1)) ptr_bad++;
      end
      if (cur > FRAME_BITS - 1) ptr_bad++;
      prev_ptr = cur;
      if (axis_if.tvalid === 1'b1 && first_valid < 0) first_valid = cyc;
      if (frame_done === 1'b1) begin
        done_cnt++;
        if (done_cycle < 0) done_cycle = cyc;
      end
      if (done_cycle >= 0 && cyc >= done_cycle + 3) break;
      if (mode == 3 && axis_if.tvalid === 1'b1 && beats.size() == 19) begin
        reset = 1'b1;
        buff_full = 1'b0;
        axis_if.tready = 1'b0;
        tick();
        reset = 1'b0;
        rst_tvalid = int'(axis_if.tvalid);
        rst_tlast  = int'(axis_if.tlast);
        rst_busy   = int'(busy);
        rst_ptr    = int'(rd_pointer);
        rst_after_bad = 0;
        for (int k = 0; k < 40; k++) begin
          tick();
          if (frame_done !== 1'b0 || axis_if.tvalid !== 1'b0 || axis_if.tlast !== 1'b0 || busy !== 1'b0)
            rst_after_bad++;
        end
        return;
      end
      case (mode)
        1: rdy = 1'($urandom_range(0, 1));
        2: begin
          rdy = 1'b1;
          if (axis_if.tvalid === 1'b1 && beats.size() == 2 && stall_cycles < 10) begin
            rdy = 1'b0;
            stall_cycles++;
            if (rd_pointer !== 8'd11 || axis_if.tdata !== exp_sym(2)) stall_bad++;
          end
        end
        default: rdy = 1'b1;
      endcase
      axis_if.tready = rdy;
      prev_hold = (axis_if.tvalid === 1'b1) && !rdy;
      prev_data = axis_if.tdata;
      prev_last = axis_if.tlast;
      if (axis_if.tvalid === 1'b1 && rdy) begin
        beats.push_back(axis_if.tdata);
        if (axis_if.tlast === 1'b1) begin
          tlast_cnt++;
          tlast_idx = beats.size();
        end
      end
    end
    timed_out = (done_cycle < 0);
    axis_if.tready = 1'b0;
  endtask

  task automatic rearm();
    buff_full = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; buff_full = 1'b0; axis_if.tready = 1'b0; frame_mem = '0;
    tick(); tick();
    reset = 1'b0;
    n_compared++;
    if (rd_pointer !== 8'd0) begin n_mismatched++; $display("[TB] FAIL reset_rd_pointer: got %0d expected 0", rd_pointer); end
    n_compared++;
    if (axis_if.tdata !== 4'd0) begin n_mismatched++; $display("[TB] FAIL reset_tdata: got %0h expected 0", axis_if.tdata); end
    n_compared++;
    if (axis_if.tvalid !== 1'b0 || axis_if.tlast !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL reset_tvalid_tlast: got %b%b expected 00", axis_if.tvalid, axis_if.tlast);
    end
    n_compared++;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL reset_done_busy: got %b%b expected 00", frame_done, busy);
    end
  endtask

  task automatic test_basic_frame();
    logic [3:0] first4[4];
`ifdef OFDM_TX_GRAY_MAP_EN
    first4 = '{4'h7, 4'hF, 4'h0, 4'h8};
`else
    first4 = '{4'h5, 4'hA, 4'h0, 4'hF};
`endif
    randomize_frame();
    frame_mem[15:0] = 16'hF0A5;
    run_frame(0);
    n_compared++;
    if (timed_out || beats.size() != SYMS) begin
      n_mismatched++; $display("[TB] FAIL basic_beats: got %0d beats (timeout=%0d) expected %0d", beats.size(), timed_out, SYMS);
    end
    for (int i = 0; i < 4 && i < beats.size(); i++) begin
      n_compared++;
      if (beats[i] !== first4[i]) begin n_mismatched++; $display("[TB] FAIL basic_sym%0d: got %h expected %h", i, beats[i], first4[i]); end
    end
    for (int i = 0; i < beats.size(); i++) begin
      n_compared++;
      if (beats[i] !== exp_sym(i)) begin n_mismatched++; $display("[TB] FAIL basic_model_beat%0d: got %h expected %h", i, beats[i], exp_sym(i)); end
    end
    n_compared++;
    if (tlast_cnt != 1 || tlast_idx != SYMS) begin
      n_mismatched++; $display("[TB] FAIL basic_tlast: got count %0d at beat %0d expected 1 at %0d", tlast_cnt, tlast_idx, SYMS);
    end
    n_compared++;
    if (first_valid != BPS + 2) begin n_mismatched++; $display("[TB] FAIL basic_first_valid: got %0d expected %0d", first_valid, BPS + 2); end
    n_compared++;
    if (done_cycle != 337 || done_cnt != 1) begin
      n_mismatched++; $display("[TB] FAIL basic_frame_done: got cycle %0d count %0d expected 337 1", done_cycle, done_cnt);
    end
    n_compared++;
    if (ptr_steps != FRAME_BITS - 1 || ptr_bad != 0) begin
      n_mismatched++; $display("[TB] FAIL basic_rd_pointer: got steps %0d bad %0d expected %0d 0", ptr_steps, ptr_bad, FRAME_BITS - 1);
    end
  endtask

  task automatic test_no_rearm();
    int bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (busy !== 1'b0 || axis_if.tvalid !== 1'b0 || frame_done !== 1'b0 || rd_pointer !== 8'd0) bad++;
    end
    n_compared++;
    if (bad != 0) begin n_mismatched++; $display("[TB] FAIL no_rearm_idle: got %0d active cycles expected 0", bad); end
    randomize_frame();
    rearm();
    run_frame(0);
    n_compared++;
    if (busy_at1 != 1) begin n_mismatched++; $display("[TB] FAIL rearm_start: got busy %0d expected 1", busy_at1); end
    n_compared++;
    if (timed_out || done_cycle != 337 || beats.size() != SYMS) begin
      n_mismatched++; $display("[TB] FAIL rearm_frame: got done %0d beats %0d expected 337 %0d", done_cycle, beats.size(), SYMS);
    end
  endtask

  task automatic test_back_pressure();
    int bad = 0;
    randomize_frame();
    frame_mem[15:0] = 16'hF0A5;
    rearm();
    run_frame(2);
    n_compared++;
    if (stall_cycles != 10 || stall_bad != 0 || stable_bad != 0) begin
      n_mismatched++; $display("[TB] FAIL stall_hold: got stall %0d bad %0d unstable %0d expected 10 0 0", stall_cycles, stall_bad, stable_bad);
    end
    for (int i = 0; i < beats.size(); i++) if (beats[i] !== exp_sym(i)) bad++;
    n_compared++;
    if (timed_out || beats.size() != SYMS || bad != 0) begin
      n_mismatched++; $display("[TB] FAIL stall_stream: got %0d beats %0d wrong expected %0d 0", beats.size(), bad, SYMS);
    end
    n_compared++;
    if (done_cycle != 347) begin n_mismatched++; $display("[TB] FAIL stall_done_cycle: got %0d expected 347", done_cycle); end
  endtask

  task automatic test_reset_mid_frame();
    int bad = 0;
    randomize_frame();
    rearm();
    run_frame(3);
    n_compared++;
    if (beats.size() != 19 || tlast_cnt != 0 || done_cnt != 0) begin
      n_mismatched++; $display("[TB] FAIL midreset_prefix: got beats %0d tlast %0d done %0d expected 19 0 0", beats.size(), tlast_cnt, done_cnt);
    end
    n_compared++;
    if (rst_tvalid != 0 || rst_tlast != 0 || rst_busy != 0 || rst_ptr != 0) begin
      n_mismatched++; $display("[TB] FAIL midreset_state: got v%0d l%0d b%0d p%0d expected 0 0 0 0", rst_tvalid, rst_tlast, rst_busy, rst_ptr);
    end
    n_compared++;
    if (rst_after_bad != 0) begin n_mismatched++; $display("[TB] FAIL midreset_quiet: got %0d active cycles expected 0", rst_after_bad); end
    randomize_frame();
    run_frame(0);
    for (int i = 0; i < beats.size(); i++) if (beats[i] !== exp_sym(i)) bad++;
    n_compared++;
    if (timed_out || beats.size() != SYMS || bad != 0 || first_valid != BPS + 2 || ptr_steps != FRAME_BITS - 1) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_restart: got beats %0d wrong %0d first %0d steps %0d expected %0d 0 %0d %0d",
               beats.size(), bad, first_valid, ptr_steps, SYMS, BPS + 2, FRAME_BITS - 1);
    end
  endtask

  task automatic test_gray_map();
    logic [3:0] want[3];
`ifdef OFDM_TX_GRAY_MAP_EN
    want = '{4'hF, 4'h7, 4'h2};
`else
    want = '{4'hA, 4'h5, 4'h3};
`endif
    randomize_frame();
    frame_mem[11:0] = 12'h35A;
    rearm();
    run_frame(0);
    for (int i = 0; i < 3; i++) begin
      n_compared++;
      if (i >= beats.size() || beats[i] !== want[i]) begin
        n_mismatched++;
        $display("[TB] FAIL map_sym%0d: got %h expected %h", i, (i < beats.size()) ? beats[i] : 4'hx, want[i]);
      end
    end
  endtask

  task automatic test_random_ready();
    for (int f = 0; f < 4; f++) begin
      int bad = 0;
      randomize_frame();
      rearm();
      run_frame(1);
      for (int i = 0; i < beats.size(); i++) if (beats[i] !== exp_sym(i)) bad++;
      n_compared++;
      if (timed_out || beats.size() != SYMS || bad != 0 || tlast_idx != SYMS || done_cnt != 1) begin
        n_mismatched++;
        $display("[TB] FAIL random_frame%0d: got beats %0d wrong %0d tlast@%0d done %0d expected %0d 0 %0d 1",
                 f, beats.size(), bad, tlast_idx, done_cnt, SYMS, SYMS);
      end
      n_compared++;
      if (stable_bad != 0 || ptr_bad != 0) begin
        n_mismatched++; $display("[TB] FAIL random_stable%0d: got unstable %0d ptr_bad %0d expected 0 0", f, stable_bad, ptr_bad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_no_rearm();
    test_back_pressure();
    test_reset_mid_frame();
    test_gray_map();
    test_random_ready();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
